sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO. Next generation of the team's FIFO DUT, with configurable width and depth, programmable almost-full/almost-empty thresholds, a fill-level output and sticky overflow/underflow error flags.
- Serves as the same-clock buffering stage in the FIFO family and as the reference DUT for the next UVM/SVA environment.
- Interface names data_in, w_en, r_en, data_out, empty, full match the existing FIFO interface, so benches reuse them.

Parameters:
- FIFO_WIDTH, 32, data bits per entry.
- FIFO_DEPTH, 8, number of entries; power of 2, at least 2.
- AF_LEVEL, FIFO_DEPTH-2, almost_full asserts when fill_level >= AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when fill_level <= AE_LEVEL.
- CW (localparam), $clog2(FIFO_DEPTH)+1, width of fill_level.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  FIFO_WIDTH  write data.
- w_en  in  1  write request.
- r_en  in  1  read request.
- clr_err  in  1  synchronous one-cycle pulse; clears overflow and underflow.
- data_out  out  FIFO_WIDTH  read data.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- almost_empty  out  1  fill_level <= AE_LEVEL.
- almost_full  out  1  fill_level >= AF_LEVEL.
- fill_level  out  CW  current entry count, 0..FIFO_DEPTH.
- overflow  out  1  sticky; a write was rejected.
- underflow  out  1  sticky; a read was rejected.

Behaviour:
- Reset (asynchronous assert, synchronous release): wr_ptr=0, rd_ptr=0, fill_level=0, empty=1, full=0, almost_empty=1, almost_full=0, data_out=0, overflow=0, underflow=0. Memory contents are not reset.
- Reset mid-operation: all state clears immediately; any in-flight read or write is lost; no error flags are set.
- Read acceptance: rd_acc = r_en & !empty.
- Write acceptance: wr_acc = w_en & (!full | rd_acc).
- Full plus simultaneous read and write: both are accepted; fill_level stays at FIFO_DEPTH; no overflow.
- Empty plus simultaneous read and write: read is rejected and underflow sets; write is accepted; fill_level becomes 1.
- Pointers: wr_ptr and rd_ptr are $clog2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0.
- fill_level update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither occur.
- All flags are registered and reflect the post-update fill_level in the cycle after the edge. No combinational paths from inputs to outputs.
- Normal read timing: on rd_acc, data_out <= mem[rd_ptr] at the same edge (1-cycle latency). data_out holds its value otherwise.
- overflow sets on w_en & !wr_acc.
- underflow sets on r_en & !rd_acc.
- Error flags stay set until clr_err or reset. If clr_err coincides with a new error event, the flag remains 1.
- Threshold legality: parameters must satisfy AE_LEVEL < AF_LEVEL <= FIFO_DEPTH. An elaboration-time $error fires otherwise.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out presents mem[rd_ptr] from a registered output stage whenever empty=0.
  - r_en acknowledges and pops the current word; the next word appears on the following cycle.
  - A write into an empty FIFO appears on data_out, with empty=0, one cycle after the write edge.
  - Acceptance rules, flags and error behaviour are unchanged.
- Undefined: the normal 1-cycle read latency described in Behaviour applies.

Test Plan:
- Fill to full: DEPTH=8, AF=6, AE=1; reset, then 8 writes 0x10..0x17.
  - fill_level 1..8; almost_empty drops after write 2; almost_full rises at write 6; full=1 after write 8; overflow=0.
- Overflow: a 9th write 0xFF on a full FIFO -> overflow=1, fill_level=8, memory unchanged. Then pulse clr_err -> overflow=0 next cycle.
- Drain: 8 reads -> data_out 0x10..0x17 in order at 1-cycle latency; empty=1 after read 8.
- Underflow: a 9th read on an empty FIFO -> underflow=1, data_out holds 0x17.
- Simultaneous access:
  - Full FIFO with w_en=r_en=1 and data 0xAA -> fill_level stays 8, overflow=0, 0xAA read out 8 reads later.
  - Empty FIFO with w_en=r_en=1 -> underflow=1, fill_level=1.
- Wrap and reset: 20 write/read pairs cross the pointer wrap, data stays in order. Then assert rst_n low mid-burst -> all outputs return to reset values immediately, overflow/underflow=0.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with programmable
// almost-full/almost-empty thresholds, a fill-level output and sticky
// overflow/underflow flags.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through output;
// when undefined, reads have a 1-cycle latency.
module sync_fifo_param #(
    parameter int unsigned FIFO_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 1,
    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic                  clr_err,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [CW-1:0]         fill_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    // Reject illegal configurations at elaboration time
    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= FIFO_DEPTH))) begin : g_bad_thresholds
        $error("sync_fifo_param: thresholds must satisfy AE_LEVEL < AF_LEVEL <= FIFO_DEPTH");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr_nxt;
    logic [AW-1:0]         rd_ptr_nxt;
    logic [CW-1:0]         fill_nxt;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  overflow_nxt;
    logic                  underflow_nxt;

    // Acceptance: a read needs data; a write needs space or a same-cycle pop
    always_comb begin
        rd_acc = r_en & ~empty;
        wr_acc = w_en & (~full | rd_acc);
    end

    // Next pointers, fill level and sticky error flags
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        fill_nxt   = fill_level;
        if (wr_acc) begin
            wr_ptr_nxt = wr_ptr + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   fill_nxt = fill_level + CW'(1);
            2'b01:   fill_nxt = fill_level - CW'(1);
            default: fill_nxt = fill_level;
        endcase
        // A new error in the clearing cycle wins over the clear
        overflow_nxt  = (overflow  & ~clr_err) | (w_en & ~wr_acc);
        underflow_nxt = (underflow & ~clr_err) | (r_en & ~rd_acc);
    end

    // Storage array; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, fill level and status flags, all from the post-update count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_level   <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            fill_level   <= fill_nxt;
            empty        <= (fill_nxt == '0);
            full         <= (fill_nxt == CW'(FIFO_DEPTH));
            almost_empty <= (fill_nxt <= CW'(AE_LEVEL));
            almost_full  <= (fill_nxt >= CW'(AF_LEVEL));
            overflow     <= overflow_nxt;
            underflow    <= underflow_nxt;
        end
    end

`ifdef FIFO_FWFT_EN
    logic [FIFO_WIDTH-1:0] head_c;

    // Next head word; bypass the write data when it lands in the head slot
    always_comb begin
        head_c = mem[rd_ptr_nxt];
        if (wr_acc && (wr_ptr == rd_ptr_nxt)) begin
            head_c = data_in;
        end
    end

    // Registered fall-through stage: always shows the head while non-empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (fill_nxt != '0) begin
            data_out <= head_c;
        end
    end
`else
    // Standard read port: data appears one cycle after the accepted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (rd_acc) begin
            data_out <= mem[rd_ptr];
        end
    end
`endif

endmodule
